cic_pcm_fifo: RTL and testbench

//  Output stage directly downstream of the CIC comb. Takes one signed DW-bit PCM

---
 rtl/cic_pcm_fifo.sv | 227 ++++++++++++++++++++++
 tb/tb_cic_pcm_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cic_pcm_fifo.sv
// cic_pcm_fifo: output stage behind the CIC comb.
// Drops the warm-up samples after every oversampling-ratio change, buffers the
// remaining PCM samples in a small show-ahead FIFO and serves them over a
// valid/ready read port. Also reports fill level, almost-full and sticky overflow.
module cic_pcm_fifo #(
  parameter int DW     = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int WARMUP = 8,
  parameter int AFULL  = 12
) (
  input  logic                 clk_div,
  input  logic                 reset_n,
  input  logic [2:0]           os_sel,
  input  logic signed [DW-1:0] pcm_in,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic signed [DW-1:0] rd_data,
  output logic [AW:0]          level,
  output logic                 almost_full,
  output logic                 overflow,
  input  logic                 ovf_clr,
  output logic                 running
);

  localparam int             WCW       = $clog2(WARMUP + 1);
  localparam logic [WCW-1:0] WARM_INIT = WCW'(WARMUP);
  localparam logic [WCW-1:0] WARM_LAST = WCW'(1);
  localparam logic [AW:0]    FULL_LVL  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]    AFULL_LVL = (AW + 1)'(AFULL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [2:0]           os_sel_q;
  logic                 chg;
  logic [WCW-1:0]       warm_cnt;

  // Control strobes decoded by the FSM output logic.
  logic                 flush;
  logic                 warm_load;
  logic                 warm_dec;
  logic                 wr_try;

  // FIFO storage and bookkeeping.
  logic signed [DW-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 full;
  logic                 pop;
  logic                 wr_en;
  logic                 ovf_set;

  assign chg = (os_sel != os_sel_q);

  // Remember last cycle's oversampling select to detect ratio changes.
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      os_sel_q <= '0;
    end else begin
      os_sel_q <= os_sel;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: disable beats everything, then (re)start, then ratio change.
  always_comb begin
    state_d = state_q;
    if (os_sel == 3'd0) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = WARM;
        WARM: begin
          if (chg) begin
            state_d = WARM;
          end else if (warm_cnt == WARM_LAST) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (chg) begin
            state_d = WARM;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: flush and warm-up reload on any (re)start, countdown in WARM,
  // write attempt every RUN cycle.
  always_comb begin
    flush     = 1'b0;
    warm_load = 1'b0;
    warm_dec  = 1'b0;
    wr_try    = 1'b0;
    if (os_sel == 3'd0) begin
      flush     = 1'b1;
      warm_load = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          flush     = 1'b1;
          warm_load = 1'b1;
        end
        WARM: begin
          if (chg) begin
            flush     = 1'b1;
            warm_load = 1'b1;
          end else begin
            warm_dec = 1'b1;
          end
        end
        RUN: begin
          if (chg) begin
            flush     = 1'b1;
            warm_load = 1'b1;
          end else begin
            wr_try = 1'b1;
          end
        end
        default: begin
          flush     = 1'b1;
          warm_load = 1'b1;
        end
      endcase
    end
  end

  // Warm-up counter: number of stale samples still to discard.
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      warm_cnt <= WARM_INIT;
    end else if (warm_load) begin
      warm_cnt <= WARM_INIT;
    end else if (warm_dec) begin
      warm_cnt <= warm_cnt - 1'b1;
    end
  end

  // Full/empty come from the level counter, not from pointer comparison.
  assign full     = (level == FULL_LVL);
  assign rd_valid = (level != '0);

  // A pop during a flush is discarded together with the rest of the contents.
  assign pop      = rd_valid & rd_ready & ~flush;

  // When full, a write only fits if the head leaves in the same cycle.
  assign wr_en    = wr_try & (~full | pop);
  assign ovf_set  = wr_try & full & ~pop;

  // Sample storage; intentionally not reset.
  always_ff @(posedge clk_div) begin
    if (wr_en) begin
      mem[wr_ptr] <= pcm_in;
    end
  end

  // Write pointer, wraps naturally at DEPTH.
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Read pointer, wraps naturally at DEPTH.
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Fill level: simultaneous write and pop cancel out.
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
    end else if (flush) begin
      level <= '0;
    end else begin
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow: a fresh drop outranks a clear in the same cycle.
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // Show-ahead head sample, forced to zero while the FIFO is empty.
  assign rd_data     = rd_valid ? mem[rd_ptr] : '0;

  assign almost_full = (level >= AFULL_LVL);
  assign running     = (state_q == RUN);

endmodule

// File: tb/tb_cic_pcm_fifo.sv
// tb_cic_pcm_fifo: directed, table-driven bench for cic_pcm_fifo
// (DW=16, DEPTH=16, WARMUP=8, AFULL=12). pcm_in is a ramp equal to the
// row's cycle index so every expected head value is easy to derive.
module tb_cic_pcm_fifo;

  logic               clk_div = 1'b0;
  logic               reset_n;
  logic [2:0]         os_sel;
  logic signed [15:0] pcm_in;
  logic               rd_valid;
  logic               rd_ready;
  logic signed [15:0] rd_data;
  logic [4:0]         level;
  logic               almost_full;
  logic               overflow;
  logic               ovf_clr;
  logic               running;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  os_sel;
    logic [15:0] pcm;
    logic        rdy;
    logic        clr;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [4:0]  exp_level;
    logic        exp_af;
    logic        exp_ovf;
    logic        exp_run;
  } vec_t;

  vec_t vecs[$];
  int   n1;

  cic_pcm_fifo #(
    .DW(16), .DEPTH(16), .AW(4), .WARMUP(8), .AFULL(12)
  ) dut (
    .clk_div     (clk_div),
    .reset_n     (reset_n),
    .os_sel      (os_sel),
    .pcm_in      (pcm_in),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .level       (level),
    .almost_full (almost_full),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .running     (running)
  );

  always #5 clk_div = ~clk_div;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [2:0] os, input int pcm, input logic rdy,
                              input logic clr, input logic v, input int d, input int l,
                              input logic af, input logic ovf, input logic run);
    vec_t r;
    r.os_sel    = os;
    r.pcm       = 16'(pcm);
    r.rdy       = rdy;
    r.clr       = clr;
    r.exp_valid = v;
    r.exp_data  = 16'(d);
    r.exp_level = 5'(l);
    r.exp_af    = af;
    r.exp_ovf   = ovf;
    r.exp_run   = run;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic v, input logic [15:0] d,
                               input logic [4:0] l, input logic af, input logic ovf,
                               input logic run);
    check({tag, ".rd_valid"},    {31'd0, rd_valid},    {31'd0, v});
    check({tag, ".rd_data"},     {16'd0, rd_data},     {16'd0, d});
    check({tag, ".level"},       {27'd0, level},       {27'd0, l});
    check({tag, ".almost_full"}, {31'd0, almost_full}, {31'd0, af});
    check({tag, ".overflow"},    {31'd0, overflow},    {31'd0, ovf});
    check({tag, ".running"},     {31'd0, running},     {31'd0, run});
  endtask

  task automatic apply_row(input vec_t r, input string tag);
    os_sel   = r.os_sel;
    pcm_in   = r.pcm;
    rd_ready = r.rdy;
    ovf_clr  = r.clr;
    @(posedge clk_div);
    #1;
    check_outputs(tag, r.exp_valid, r.exp_data, r.exp_level, r.exp_af, r.exp_ovf, r.exp_run);
  endtask

  initial begin
    // T1: start from IDLE, ramp, consumer always ready. Edge 0 moves to WARM,
    // edges 1..8 discard, RUN after edge 8, first stored sample is 9.
    for (int k = 0; k <= 10; k++)
      vecs.push_back(mk(3'd3, k, 1'b1, 1'b0, k >= 9, (k >= 9) ? k : 0, (k >= 9) ? 1 : 0,
                        1'b0, 1'b0, k >= 8));
    // Disable: flush, pop ignored.
    vecs.push_back(mk(3'd0, 11, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0));
    // T2: restart with consumer stalled. RUN after edge 20, writes 21.. from edge 21,
    // full at edge 36, first dropped write at edge 37.
    for (int k = 12; k <= 40; k++)
      vecs.push_back(mk(3'd3, k, 1'b0, 1'b0, k >= 21, (k >= 21) ? 21 : 0,
                        (k <= 20) ? 0 : ((k >= 36) ? 16 : k - 20),
                        k >= 32, k >= 37, k >= 20));
    // T3: one pop while full: 21 leaves, 41 enters at the tail.
    vecs.push_back(mk(3'd3, 41, 1'b1, 1'b0, 1'b1, 22, 16, 1'b1, 1'b1, 1'b1));
    // T5: clear while full and stalled loses to a new drop (42 dropped).
    vecs.push_back(mk(3'd3, 42, 1'b0, 1'b1, 1'b1, 22, 16, 1'b1, 1'b1, 1'b1));
    // T5: clear with a pop in the same cycle succeeds.
    vecs.push_back(mk(3'd3, 43, 1'b1, 1'b1, 1'b1, 23, 16, 1'b1, 1'b0, 1'b1));
    // Drain-through: remaining originals 24..36, then 41, 43, 44 in order.
    for (int k = 44; k <= 56; k++)
      vecs.push_back(mk(3'd3, k, 1'b1, 1'b0, 1'b1, k - 20, 16, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(3'd3, 57, 1'b1, 1'b0, 1'b1, 41, 16, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(3'd3, 58, 1'b1, 1'b0, 1'b1, 43, 16, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(3'd3, 59, 1'b1, 1'b0, 1'b1, 44, 16, 1'b1, 1'b0, 1'b1));
    // T4 setup: disable, restart, fill to level 5 (samples 70..74).
    vecs.push_back(mk(3'd0, 60, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0));
    for (int k = 61; k <= 69; k++)
      vecs.push_back(mk(3'd3, k, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, k == 69));
    for (int k = 70; k <= 74; k++)
      vecs.push_back(mk(3'd3, k, 1'b0, 1'b0, 1'b1, 70, k - 69, 1'b0, 1'b0, 1'b1));
    // T4: ratio change 3->5 flushes and re-enters WARM.
    vecs.push_back(mk(3'd5, 75, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0));
    for (int k = 76; k <= 83; k++)
      vecs.push_back(mk(3'd5, k, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, k == 83));
    // RUN resumes with sample 84; reach level 7 for T6.
    for (int k = 84; k <= 90; k++)
      vecs.push_back(mk(3'd5, k, 1'b0, 1'b0, 1'b1, 84, k - 83, 1'b0, 1'b0, 1'b1));
    n1 = vecs.size();
    // T6 follow-up: after reset release, identical to T1.
    for (int k = 0; k <= 10; k++)
      vecs.push_back(mk(3'd3, k, 1'b1, 1'b0, k >= 9, (k >= 9) ? k : 0, (k >= 9) ? 1 : 0,
                        1'b0, 1'b0, k >= 8));

    // Power-on reset with active-looking inputs.
    reset_n  = 1'b0;
    os_sel   = 3'd3;
    pcm_in   = 16'sd5;
    rd_ready = 1'b1;
    ovf_clr  = 1'b0;
    repeat (2) @(posedge clk_div);
    #1;
    check_outputs("reset", 1'b0, 16'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    os_sel = 3'd0;
    @(negedge clk_div);
    reset_n = 1'b1;

    for (int i = 0; i < n1; i++)
      apply_row(vecs[i], $sformatf("row%0d", i));

    // T6: asynchronous reset mid-RUN (level 7), checked before the next edge.
    #3;
    reset_n = 1'b0;
    #1;
    check_outputs("async_reset", 1'b0, 16'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    os_sel   = 3'd3;
    pcm_in   = 16'sd0;
    rd_ready = 1'b1;
    @(posedge clk_div);
    #1;
    check_outputs("reset_held", 1'b0, 16'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_div);
    reset_n = 1'b1;

    for (int i = n1; i < vecs.size(); i++)
      apply_row(vecs[i], $sformatf("post_reset_row%0d", i - n1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
